instr_fetch_queue: RTL and testbench
====================================

# instr_fetch_queue

Fetch stage for the pipelined CPU: owns the program counter, reads the combinational instruction memory every cycle, and buffers fetched instructions in a small FIFO in front of the IF/ID boundary. This decouples fetch from ID-stage stalls and gives a single flush point for taken branches resolved in MEM. Each entry delivers the instruction and its PC+4 to the ID stage under a valid/ready handshake.

## Interface
- DEPTH, 4, number of queue entries; power of two, at least 2
- RESET_PC, 32'h0000_0000, fetch address loaded on reset
- clk_i  in  1  single clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high)
- imem_addr_o  out  32  current fetch address to instruction memory (equals fetch PC)
- imem_instr_i  in  32  instruction at imem_addr_o, same cycle (combinational memory)
- redirect_i  in  1  taken branch from MEM stage; flush and refetch
- redirect_addr_i  in  32  branch target; bits [1:0] ignored (treated as 0)
- id_ready_i  in  1  ID stage accepts the head entry this cycle (low = stall)
- id_valid_o  out  1  head entry valid
- id_instr_o  out  32  head instruction; 0 (NOP) when id_valid_o=0
- id_pc_plus_four_o  out  32  head PC+4; 0 when id_valid_o=0
- count_o  out  $clog2(DEPTH)+1  occupied entries, 0..DEPTH

## Operation
- State: fetch PC, DEPTH-entry storage of {pc_plus_four, instr}, read/write pointers (mod DEPTH), count.
- pop = id_valid_o & id_ready_i; id_valid_o = (count != 0).
- push = ~redirect_i & (count < DEPTH | pop). On push: write {fetch_pc+4, imem_instr_i} at write pointer, fetch_pc <= fetch_pc+4 (mod 2^32 wrap).
- Push and pop in same cycle: count unchanged; allowed at full (slot freed by pop is reused).
- Full and no pop: no push, fetch_pc holds, imem_addr_o stable.
- redirect_i=1: highest priority over push, pop and stall. Next edge: count<=0, pointers<=0, fetch_pc<={redirect_addr_i[31:2],2'b00}. Head entry at the redirect cycle is not considered consumed by this block (ID/EX flushing is the CPU's job).
- rst_i=1: fetch_pc<=RESET_PC, count/pointers<=0; overrides redirect_i; any cycle, including mid-stall or mid-flush.
- Reset outputs: imem_addr_o=RESET_PC, id_valid_o=0, id_instr_o=0, id_pc_plus_four_o=0, count_o=0.

## Timing
- Fetch-to-ID latency: 1 cycle (push at edge N, visible on id_* in cycle N+1).
- After reset release, cycle 0: imem_addr_o=RESET_PC, push; cycle 1: id_valid_o=1, id_pc_plus_four_o=RESET_PC+4.
- Redirect in cycle N: cycle N+1 id_valid_o=0, imem_addr_o=target; cycle N+2 target instruction valid. Bubble of exactly one cycle.
- Sustained throughput with id_ready_i=1: one instruction per cycle, count_o steady at 1.
- id_ready_i low for k cycles from count=1: count rises by 1/cycle, saturates at DEPTH; fetch_pc stops advancing at full.
- id_* outputs are driven from registered storage only (no combinational path from imem_instr_i) unless the bypass below is enabled.

## Configuration
- FETCH_BYPASS_EN defined: when count=0, ~redirect_i and id_ready_i=1, imem_instr_i and fetch_pc+4 drive id_* directly in the same cycle with id_valid_o=1, fetch_pc advances, no entry written. Removes the startup and post-redirect bubble (target valid in cycle N+1). Creates a combinational path imem_instr_i -> id_instr_o.
- Not defined: strict 1-cycle latency, id_valid_o = (count != 0) only.

## Test plan
- Reset, RESET_PC=0x0, id_ready_i=1, imem returns addr-tagged words -> cycle 1 id_valid_o=1, id_pc_plus_four_o=0x4; then 0x8, 0xC one per cycle, count_o=1.
- Hold id_ready_i=0 for 6 cycles, DEPTH=4 -> count_o 1,2,3,4,4,4; imem_addr_o frozen at 0x10; release -> entries drain in order 0x4..0x10 with no loss or duplicate.
- At full, id_ready_i=1 -> simultaneous push/pop, count_o stays 4, fetch resumes at 0x10.
- redirect_i=1, redirect_addr_i=0x103 with queue at 3 and id_ready_i=0 -> next cycle count_o=0, id_valid_o=0, imem_addr_o=0x100; following cycle id_pc_plus_four_o=0x104.
- rst_i asserted together with redirect_i while full -> next cycle all outputs at reset values, imem_addr_o=RESET_PC; fetch_pc near 0xFFFF_FFFC wraps to 0x0.
- FETCH_BYPASS_EN defined: after reset cycle 0 id_valid_o=1, id_pc_plus_four_o=RESET_PC+4, count_o=0; after redirect, target valid in cycle N+1.

Source files
------------

// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bus bundle: instruction-memory port, MEM-stage redirect and the IF/ID handshake.
// Directions in signal names are as seen from the fetch queue (modport master).
interface instr_fetch_queue_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [31:0]     imem_addr_o;
  logic [31:0]     imem_instr_i;
  logic            redirect_i;
  logic [31:0]     redirect_addr_i;
  logic            id_ready_i;
  logic            id_valid_o;
  logic [31:0]     id_instr_o;
  logic [31:0]     id_pc_plus_four_o;
  logic [CntW-1:0] count_o;

  modport master (
    output imem_addr_o,
    input  imem_instr_i,
    input  redirect_i,
    input  redirect_addr_i,
    input  id_ready_i,
    output id_valid_o,
    output id_instr_o,
    output id_pc_plus_four_o,
    output count_o
  );

  modport slave (
    input  imem_addr_o,
    output imem_instr_i,
    output redirect_i,
    output redirect_addr_i,
    output id_ready_i,
    input  id_valid_o,
    input  id_instr_o,
    input  id_pc_plus_four_o,
    input  count_o
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the PC, reads the combinational imem and queues {pc+4, instr} toward ID.
// Optional same-cycle empty-queue bypass is enabled by defining FETCH_BYPASS_EN.
module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk_i,
  input logic          rst_i,
  instr_fetch_queue_if.master bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

`ifdef FETCH_BYPASS_EN
  localparam bit BypassEn = 1'b1;
`else
  localparam bit BypassEn = 1'b0;
`endif

  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     instr_q [DEPTH];
  logic [31:0]     ppf_q   [DEPTH];

  logic [31:0] pc_plus_four;
  logic        queue_empty;
  logic        queue_full;
  logic        head_valid;
  logic        bypass;
  logic        pop;
  logic        push;
  logic        wr_en;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_ppf;

  // Word alignment is forced on redirect targets, so the low bits are never read.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^bus.redirect_addr_i[1:0];

  always_comb begin
    pc_plus_four = fetch_pc_q + 32'd4;
    queue_empty  = (count_q == '0);
    queue_full   = (count_q == CntFull);
    head_valid   = ~queue_empty;
    // Bypass is held off during reset so the reset-cycle outputs stay quiet.
    bypass       = BypassEn & queue_empty & ~bus.redirect_i & bus.id_ready_i & ~rst_i;
    pop          = head_valid & bus.id_ready_i;
    push         = ~bus.redirect_i & (~queue_full | pop);
    // A bypassed fetch is consumed directly by ID and never occupies a slot.
    wr_en        = push & ~bypass;
  end

  always_comb begin
    id_valid = head_valid | bypass;
    id_instr = 32'h0;
    id_ppf   = 32'h0;
    if (head_valid) begin
      id_instr = instr_q[rd_ptr_q];
      id_ppf   = ppf_q[rd_ptr_q];
    end else if (bypass) begin
      id_instr = bus.imem_instr_i;
      id_ppf   = pc_plus_four;
    end
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (bus.redirect_i) begin
      fetch_pc_d = {bus.redirect_addr_i[31:2], 2'b00};
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        fetch_pc_d = pc_plus_four;
      end
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      case ({wr_en, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Payload storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      instr_q[wr_ptr_q] <= bus.imem_instr_i;
      ppf_q[wr_ptr_q]   <= pc_plus_four;
    end
  end

  assign bus.imem_addr_o       = fetch_pc_q;
  assign bus.id_valid_o        = id_valid;
  assign bus.id_instr_o        = id_instr;
  assign bus.id_pc_plus_four_o = id_ppf;
  assign bus.count_o           = count_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue; imem returns the address XOR a fixed tag.
module tb_instr_fetch_queue;

  localparam logic [31:0] Tag = 32'hDEAD_0000;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  instr_fetch_queue_if #(.DEPTH(4)) bus ();

  assign bus.imem_instr_i = bus.imem_addr_o ^ Tag;

  instr_fetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 0 after reset release with ready low.
  task automatic do_reset();
    rst                 = 1'b1;
    bus.redirect_i      = 1'b0;
    bus.redirect_addr_i = 32'h0;
    bus.id_ready_i      = 1'b0;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst                 = 1'b1;
    bus.redirect_i      = 1'b1;
    bus.redirect_addr_i = 32'h0000_0400;
    bus.id_ready_i      = 1'b1;
    tick();
    tick();
    bus.redirect_i = 1'b0;
    #1;
    tests_run++;
    if (bus.imem_addr_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_imem_addr: got %h expected %h", bus.imem_addr_o, 32'h0);
    end
    tests_run++;
    if (bus.id_valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_valid: got %b expected 0", bus.id_valid_o);
    end
    tests_run++;
    if (bus.id_instr_o !== 32'h0 || bus.id_pc_plus_four_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_id_data: got %h/%h expected 0/0", bus.id_instr_o,
               bus.id_pc_plus_four_o);
    end
    tests_run++;
    if (bus.count_o !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_count: got %0d expected 0", bus.count_o);
    end
    rst = 1'b0;
    #1;
`ifndef FETCH_BYPASS_EN
    tests_run++;
    if (bus.id_valid_o !== 1'b0 || bus.imem_addr_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL cycle0: got valid %b addr %h expected 0 / 0", bus.id_valid_o,
               bus.imem_addr_o);
    end
`endif
  endtask

  // Starts at cycle 0 with ready high: one instruction per cycle, count steady at 1.
  task automatic test_stream();
    for (int i = 1; i <= 3; i++) begin
      tick();
      tests_run++;
      if (bus.id_valid_o !== 1'b1 || bus.id_pc_plus_four_o !== 32'(4 * i)) begin
        tests_failed++;
        $display("FAIL stream_head[%0d]: got valid %b ppf %h expected 1 / %h", i,
                 bus.id_valid_o, bus.id_pc_plus_four_o, 32'(4 * i));
      end
      tests_run++;
      if (bus.id_instr_o !== (32'(4 * (i - 1)) ^ Tag)) begin
        tests_failed++;
        $display("FAIL stream_instr[%0d]: got %h expected %h", i, bus.id_instr_o,
                 32'(4 * (i - 1)) ^ Tag);
      end
      tests_run++;
      if (bus.count_o !== 3'd1) begin
        tests_failed++;
        $display("FAIL stream_count[%0d]: got %0d expected 1", i, bus.count_o);
      end
    end
  endtask

  // Fill to full under stall, then drain with simultaneous push/pop at full.
  task automatic test_stall_and_full();
    int exp_count [6] = '{1, 2, 3, 4, 4, 4};
    do_reset();
    bus.id_ready_i = 1'b1;
    tick();
    bus.id_ready_i = 1'b0;
    #1;
    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if (bus.count_o !== 3'(exp_count[i])) begin
        tests_failed++;
        $display("FAIL stall_count[%0d]: got %0d expected %0d", i, bus.count_o, exp_count[i]);
      end
      tests_run++;
      if (bus.imem_addr_o !== ((i < 3) ? 32'(4 * (i + 1)) : 32'h10)) begin
        tests_failed++;
        $display("FAIL stall_imem_addr[%0d]: got %h expected %h", i, bus.imem_addr_o,
                 (i < 3) ? 32'(4 * (i + 1)) : 32'h10);
      end
      tests_run++;
      if (bus.id_pc_plus_four_o !== 32'h4) begin
        tests_failed++;
        $display("FAIL stall_head[%0d]: got %h expected %h", i, bus.id_pc_plus_four_o, 32'h4);
      end
      if (i < 5) tick();
    end
    bus.id_ready_i = 1'b1;
    #1;
    for (int j = 0; j < 6; j++) begin
      tests_run++;
      if (bus.id_pc_plus_four_o !== 32'(4 + 4 * j) ||
          bus.id_instr_o !== (32'(4 * j) ^ Tag)) begin
        tests_failed++;
        $display("FAIL drain_head[%0d]: got %h/%h expected %h/%h", j, bus.id_pc_plus_four_o,
                 bus.id_instr_o, 32'(4 + 4 * j), 32'(4 * j) ^ Tag);
      end
      tests_run++;
      if (bus.count_o !== 3'd4 || bus.imem_addr_o !== 32'(16 + 4 * j)) begin
        tests_failed++;
        $display("FAIL full_pushpop[%0d]: got count %0d addr %h expected 4 / %h", j,
                 bus.count_o, bus.imem_addr_o, 32'(16 + 4 * j));
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    do_reset();
    bus.id_ready_i = 1'b1;
    tick();
    bus.id_ready_i = 1'b0;
    tick();
    tick();
    tests_run++;
    if (bus.count_o !== 3'd3) begin
      tests_failed++;
      $display("FAIL redirect_pre_count: got %0d expected 3", bus.count_o);
    end
    bus.redirect_i      = 1'b1;
    bus.redirect_addr_i = 32'h0000_0103;
    tick();
    bus.redirect_i = 1'b0;
    #1;
    tests_run++;
    if (bus.count_o !== 3'd0 || bus.id_valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL redirect_flush: got count %0d valid %b expected 0 / 0", bus.count_o,
               bus.id_valid_o);
    end
    tests_run++;
    if (bus.imem_addr_o !== 32'h100) begin
      tests_failed++;
      $display("FAIL redirect_target: got %h expected %h", bus.imem_addr_o, 32'h100);
    end
    tests_run++;
    if (bus.id_instr_o !== 32'h0 || bus.id_pc_plus_four_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL redirect_bubble_data: got %h/%h expected 0/0", bus.id_instr_o,
               bus.id_pc_plus_four_o);
    end
    tick();
    tests_run++;
    if (bus.id_valid_o !== 1'b1 || bus.id_pc_plus_four_o !== 32'h104 ||
        bus.id_instr_o !== (32'h100 ^ Tag)) begin
      tests_failed++;
      $display("FAIL redirect_refetch: got %b %h %h expected 1 %h %h", bus.id_valid_o,
               bus.id_pc_plus_four_o, bus.id_instr_o, 32'h104, 32'h100 ^ Tag);
    end
  endtask

  task automatic test_reset_over_redirect();
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    tests_run++;
    if (bus.count_o !== 3'd4) begin
      tests_failed++;
      $display("FAIL override_pre_full: got %0d expected 4", bus.count_o);
    end
    rst                 = 1'b1;
    bus.redirect_i      = 1'b1;
    bus.redirect_addr_i = 32'h0000_0200;
    tick();
    rst            = 1'b0;
    bus.redirect_i = 1'b0;
    #1;
    tests_run++;
    if (bus.imem_addr_o !== 32'h0 || bus.count_o !== 3'd0 || bus.id_valid_o !== 1'b0 ||
        bus.id_instr_o !== 32'h0 || bus.id_pc_plus_four_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL override_reset_state: got addr %h cnt %0d v %b i %h p %h expected all 0",
               bus.imem_addr_o, bus.count_o, bus.id_valid_o, bus.id_instr_o,
               bus.id_pc_plus_four_o);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    bus.id_ready_i      = 1'b1;
    bus.redirect_i      = 1'b1;
    bus.redirect_addr_i = 32'hFFFF_FFF8;
    tick();
    bus.redirect_i = 1'b0;
    #1;
    tests_run++;
    if (bus.imem_addr_o !== 32'hFFFF_FFF8) begin
      tests_failed++;
      $display("FAIL wrap_target: got %h expected %h", bus.imem_addr_o, 32'hFFFF_FFF8);
    end
    tick();
    tests_run++;
    if (bus.id_pc_plus_four_o !== 32'hFFFF_FFFC || bus.imem_addr_o !== 32'hFFFF_FFFC) begin
      tests_failed++;
      $display("FAIL wrap_pre: got ppf %h addr %h expected %h", bus.id_pc_plus_four_o,
               bus.imem_addr_o, 32'hFFFF_FFFC);
    end
    tick();
    tests_run++;
    if (bus.id_valid_o !== 1'b1 || bus.id_pc_plus_four_o !== 32'h0 ||
        bus.imem_addr_o !== 32'h0 || bus.id_instr_o !== (32'hFFFF_FFFC ^ Tag)) begin
      tests_failed++;
      $display("FAIL wrap_cross: got v %b ppf %h addr %h instr %h expected 1 0 0 %h",
               bus.id_valid_o, bus.id_pc_plus_four_o, bus.imem_addr_o, bus.id_instr_o,
               32'hFFFF_FFFC ^ Tag);
    end
  endtask

`ifdef FETCH_BYPASS_EN
  task automatic test_bypass();
    do_reset();
    bus.id_ready_i = 1'b1;
    #1;
    tests_run++;
    if (bus.id_valid_o !== 1'b1 || bus.id_pc_plus_four_o !== 32'h4 || bus.count_o !== 3'd0 ||
        bus.id_instr_o !== Tag) begin
      tests_failed++;
      $display("FAIL bypass_cycle0: got v %b ppf %h cnt %0d instr %h", bus.id_valid_o,
               bus.id_pc_plus_four_o, bus.count_o, bus.id_instr_o);
    end
    tick();
    tests_run++;
    if (bus.id_pc_plus_four_o !== 32'h8 || bus.count_o !== 3'd0) begin
      tests_failed++;
      $display("FAIL bypass_cycle1: got ppf %h cnt %0d expected 8 / 0", bus.id_pc_plus_four_o,
               bus.count_o);
    end
    bus.redirect_i      = 1'b1;
    bus.redirect_addr_i = 32'h0000_0100;
    #1;
    tests_run++;
    if (bus.id_valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL bypass_redirect_cycle: got valid %b expected 0", bus.id_valid_o);
    end
    tick();
    bus.redirect_i = 1'b0;
    #1;
    tests_run++;
    if (bus.id_valid_o !== 1'b1 || bus.id_pc_plus_four_o !== 32'h104) begin
      tests_failed++;
      $display("FAIL bypass_target: got v %b ppf %h expected 1 / %h", bus.id_valid_o,
               bus.id_pc_plus_four_o, 32'h104);
    end
  endtask
`endif

  initial begin
    tests_run           = 0;
    tests_failed        = 0;
    rst                 = 1'b1;
    bus.redirect_i      = 1'b0;
    bus.redirect_addr_i = 32'h0;
    bus.id_ready_i      = 1'b0;
    test_reset();
`ifdef FETCH_BYPASS_EN
    test_bypass();
`else
    test_stream();
    test_stall_and_full();
    test_redirect();
    test_reset_over_redirect();
    test_wrap();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
